// File: rtl/contrast_auto_ctrl.sv
// contrast_auto_ctrl
// Closed-loop auto-contrast controller. Measures the luma spread (max - min)
// of each frame of an RGB stream. At a frame boundary it may issue a single
// one-cycle inc or dec request toward the contrast block, steering the spread
// into the [TARGET_LO, TARGET_HI] window. After each request it ignores
// HOLD_FRAMES frame boundaries so the new contrast level can take effect.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        synchronous active-high reset
//   enable     master enable; when low, the FSM and accumulators are held idle
//   frame_en   one-cycle frame boundary pulse
//   pix_valid  R/G/B carry a valid pixel this cycle
//   R, G, B    8-bit colour components
//   level_in   current contrast level reported by the contrast block
//   inc, dec   one-cycle increase / decrease requests (never both high)
//   spread_out spread of the last frame that had enough pixels
//   state_out  FSM state (WAIT=0, EVAL=1, PULSE=2, COOL=3)

module contrast_auto_ctrl #(
    parameter logic [7:0]  TARGET_LO   = 8'd96,
    parameter logic [7:0]  TARGET_HI   = 8'd192,
    parameter int unsigned HOLD_FRAMES = 2,
    parameter logic [19:0] MIN_PIXELS  = 20'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_en,
    input  logic       pix_valid,
    input  logic [7:0] R,
    input  logic [7:0] G,
    input  logic [7:0] B,
    input  logic [3:0] level_in,
    output logic       inc,
    output logic       dec,
    output logic [7:0] spread_out,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        EVAL  = 2'd1,
        PULSE = 2'd2,
        COOL  = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_CNT = 4'(HOLD_FRAMES);

    state_t      state;
    state_t      state_nx;

    logic [9:0]  luma_sum;
    logic [7:0]  y;
    logic        frame_evt;
    logic        pix_evt;

    logic [7:0]  min_y;
    logic [7:0]  max_y;
    logic [19:0] pix_cnt;
    logic [7:0]  cur_spread;

    logic [7:0]  spread_l;
    logic [19:0] cnt_l;
    logic [3:0]  cool_cnt;

    logic        want_inc;
    logic        want_dec;
    logic        inc_nx;
    logic        dec_nx;

    // Luma approximation Y = (R + 2G + B) / 4, truncated; the 10-bit sum
    // cannot overflow (max 1020).
    assign luma_sum   = {2'b00, R} + {1'b0, G, 1'b0} + {2'b00, B};
    assign y          = 8'(luma_sum >> 2);

    assign frame_evt  = enable & frame_en;
    assign pix_evt    = enable & pix_valid;

    // When pix_cnt is zero this wraps to 1, but such a frame never passes
    // the MIN_PIXELS qualification so the value is never used.
    assign cur_spread = max_y - min_y;

    // Decision terms from the stats latched at the last boundary.
    // Strict compares: a spread sitting exactly on a target is left alone.
    assign want_inc = (cnt_l >= MIN_PIXELS) && (spread_l < TARGET_LO) && (level_in != 4'hF);
    assign want_dec = (cnt_l >= MIN_PIXELS) && (spread_l > TARGET_HI) && (level_in != 4'h0);

    // Per-frame min/max/count accumulation. A pixel arriving together with
    // frame_en belongs to the new frame and seeds it.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            min_y   <= 8'hFF;
            max_y   <= 8'h00;
            pix_cnt <= 20'd0;
        end else if (frame_en) begin
            if (pix_valid) begin
                min_y   <= y;
                max_y   <= y;
                pix_cnt <= 20'd1;
            end else begin
                min_y   <= 8'hFF;
                max_y   <= 8'h00;
                pix_cnt <= 20'd0;
            end
        end else if (pix_evt) begin
            if (y < min_y) begin
                min_y <= y;
            end
            if (y > max_y) begin
                max_y <= y;
            end
            if (pix_cnt != 20'hFFFFF) begin
                pix_cnt <= pix_cnt + 20'd1;
            end
        end
    end

    // Frame statistics latched at each boundary, independent of FSM state.
    // spread_out only reflects frames with enough data to be trusted.
    always_ff @(posedge clk) begin
        if (rst) begin
            spread_l   <= 8'd0;
            cnt_l      <= 20'd0;
            spread_out <= 8'd0;
        end else if (frame_evt) begin
            spread_l <= cur_spread;
            cnt_l    <= pix_cnt;
            if (pix_cnt >= MIN_PIXELS) begin
                spread_out <= cur_spread;
            end
        end
    end

    // State register; dropping enable returns the controller to WAIT.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            state <= WAIT;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. Boundaries seen in EVAL or PULSE are not evaluated.
    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    if (frame_evt) state_nx = EVAL;
            EVAL:    state_nx = (want_inc || want_dec) ? PULSE : WAIT;
            PULSE:   state_nx = COOL;
            COOL:    if (frame_evt && cool_cnt <= 4'd1) state_nx = WAIT;
            default: state_nx = WAIT;
        endcase
    end

    // Output decode: the request is chosen in EVAL and registered so that it
    // is high exactly during the PULSE cycle.
    always_comb begin
        inc_nx = 1'b0;
        dec_nx = 1'b0;
        if (state == EVAL) begin
            inc_nx = want_inc;
            dec_nx = want_dec && !want_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            inc <= 1'b0;
            dec <= 1'b0;
        end else begin
            inc <= inc_nx;
            dec <= dec_nx;
        end
    end

    // Hold-off counter, armed in PULSE and counted down only by boundaries
    // that arrive while cooling.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            cool_cnt <= 4'd0;
        end else if (state == PULSE) begin
            cool_cnt <= HOLD_CNT;
        end else if (state == COOL && frame_evt && cool_cnt != 4'd0) begin
            cool_cnt <= cool_cnt - 4'd1;
        end
    end

    assign state_out = state;

endmodule
